// File: rtl/div_cla.sv
// Restoring unsigned divider, one quotient bit per clock.
// Trial subtraction runs through a prefix carry-lookahead adder.
module cla_Nbit #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W-1:0] gg;
  logic [W-1:0] pp;

  // Kogge-Stone prefix; gg[i] ends as the carry out of bit i
  always_comb begin
    p     = a ^ b;
    g     = a & b;
    gg    = g;
    pp    = p;
    gg[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < W; d = d * 2) begin
      for (int i = W - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    sum  = p ^ {gg[W-2:0], cin};
    cout = gg[W-1];
  end

endmodule

module div_cla #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         valid,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [N:0]      a_q, a_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            valid_q;

  logic [N:0]      a_sh;
  logic [N:0]      m_inv;
  logic [N:0]      diff;
  logic            no_borrow;

  assign a_sh  = {a_q[N-1:0], q_q[N-1]};
  assign m_inv = ~{1'b0, m_q};

  cla_Nbit #(.W(N + 1)) u_cla (
    .a    (a_sh),
    .b    (m_inv),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  // next-state, iteration datapath and result capture
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d = '0;
          q_d = dividend;
          m_d = divisor;
          if (divisor != '0) begin
            cnt_d   = CW'(N);
            state_d = CALC;
          end else begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        if (no_borrow) begin
          a_d = diff;
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          a_d = a_sh;
          q_d = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = a_d[N-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      valid_q <= (state_d == DONE);
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign valid       = valid_q;
  assign busy        = (state_q != IDLE);

endmodule
